pickup_manager: RTL
===================

Name: pickup_manager

Overview:
- Parametrised next-generation pickup pool for Rail Rush. Generalises the fixed 4-slot coin pool to NUM_SLOTS slots, NUM_LANES lanes and two pickup kinds (coin, gem).
- Adds a spawn FSM that emits either single pickups or same-lane coin trails.
- Collection events are registered and report their point value, so the game FSM adds `collect_points` directly.
- Sits beside the obstacle manager; it is fed by the shared LFSR and the VGA row/col counters.

Parameters:
- NUM_SLOTS, 8, number of concurrent pickup slots (2..16).
- NUM_LANES, 3, playable lanes (2..4).
- LANE0_X, 144, x centre of lane 0.
- LANE_PITCH, 256, x distance between adjacent lane centres.
- HALF, 7, half-width of the pickup square (sprite is 2*HALF x 2*HALF).
- TRAIL_LEN, 5, coins per trail (1 disables trails).
- TRAIL_GAP, 6, active frames between trail coins.
- COIN_POINTS, 50, value of one coin.
- GEM_POINTS, 250, value of one gem.
- COLLECT_RANGE, 35, vertical pickup window above player_y.
- DEACTIVATE_Y, 620, y at or beyond which a slot retires.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- frame_done  in  1  one-cycle pulse at end of frame.
- game_active  in  1  game running; state advances only when high.
- clear  in  1  synchronous flush of all slots and the FSM.
- lfsr_val  in  16  shared random source.
- speed  in  4  pixels moved per active frame.
- player_lane  in  2  player lane.
- player_y  in  10  player top y.
- row, col  in  10 each  current pixel.
- magnet_on  in  1  magnet power-up active (present only with PICKUP_MAGNET_EN).
- pickup_pixel  out  1  current pixel lies inside any active pickup.
- pickup_is_gem  out  1  the pickup at the current pixel is a gem.
- collect_pulse  out  1  one-cycle collection event.
- collect_points  out  12  points for this event.
- collect_count  out  5  pickups collected in this event.

Behaviour:
- Reset (reset_n low, async):
  - all slots inactive; lane, y and kind cleared.
  - FSM in S_WAIT with spawn_timer = 30.
  - collect_pulse, collect_points and collect_count = 0.
- Update edge: the clock edge where frame_done && game_active. No other edge changes slot or FSM state.
- clear (any edge, takes priority over the update edge): same state as reset except the outputs drop on the next edge.
- Collection, evaluated on the update edge from pre-edge state:
  - slot i is hit if active[i], lane[i]==player_lane, y[i] >= sat0(player_y-COLLECT_RANGE) and y[i] <= player_y+10.
  - sat0 clamps underflow to 0.
  - Hit slots retire on this edge.
  - On the following cycle collect_pulse=1 for exactly one cycle.
  - collect_count = number of hit slots; collect_points = sum of their values. Simultaneous hits are summed, never dropped.
  - Outputs return to 0 after the pulse cycle.
- Movement: a non-hit active slot takes y += speed (10-bit). It retires if its pre-edge y >= DEACTIVATE_Y.
- Spawn target: the lowest-index slot that is inactive before the edge. A slot retiring on the same edge is not reusable until the next update.
- Spawn lane: lfsr_val[5:4]; values >= NUM_LANES map to lane 0.
- Spawn FSM:
  - S_WAIT:
    - If timer > 0: decrement.
    - Else if lfsr_val[3] and TRAIL_LEN > 1: latch the lane, spawn a coin, set remaining = TRAIL_LEN-1 and gap = TRAIL_GAP, go to S_TRAIL.
    - Else: spawn one pickup; kind = gem when lfsr_val[9:7]==7, otherwise coin. Reload timer = 55 + lfsr_val[15:10].
  - S_TRAIL:
    - If gap > 0: decrement.
    - Else: spawn a coin in the latched lane, decrement remaining, reload gap. When remaining reaches 0, reload the timer and go to S_WAIT.
  - Every spawn places the pickup at y = 0.
  - Pool full at a spawn point: that pickup is dropped. Timer and trail counters still advance.
- Game pause (game_active low): state is frozen and pixel output continues.
- Rendering (combinational):
  - cx = LANE0_X + lane*LANE_PITCH.
  - Hit when col >= cx-HALF, col < cx+HALF, row >= y and row < y+2*HALF.
  - pickup_is_gem comes from the lowest-index hit slot.

Optional Feature:
- PICKUP_MAGNET_EN defined: the magnet_on port exists. While magnet_on is high, the lane-equality term of the collection test is ignored, so pickups in any lane are collected.
- Undefined: the port is absent and collection always requires the lane match.

Decomposition:
- Package `pickup_pkg`:
  - `pickup_kind_t` enum: COIN, GEM.
  - `spawn_state_t` enum: S_WAIT, S_TRAIL.
  - `kind_points()` function.
  - Shared lane-centre function, reused by obstacle_manager.
- Sub-module `pickup_spawner`: the FSM, timers and lane/kind selection. It outputs spawn_req, spawn_lane and spawn_kind.

Test Plan:
- Reset mid-game with 3 slots active -> all outputs 0 immediately, no pixel drawn, first spawn after 30 active frames.
- lfsr_val=16'h0000, 31 active frames -> one coin in lane 0 at y=0; pixel hit at (row 0, col 137), no hit at (row 0, col 151).
- Force a trail (lfsr_val[3]=1, TRAIL_LEN=5) -> 5 coins in one lane, spawned 7 active frames apart.
- Coin and gem in the player's lane entering the window on the same frame -> one collect_pulse, collect_count=2, collect_points=300.
- NUM_SLOTS=2, trail started with both slots busy -> trail coins dropped with no overwrite; FSM still returns to S_WAIT after 5 spawn points.
- PICKUP_MAGNET_EN with magnet_on=1, coin in lane 2 and player in lane 0 -> collected, collect_points=50.

Source files
------------

// File: rtl/pickup_pkg.sv
// Shared types and helpers for the Rail Rush pickup pool; lane_centre is also
// used by obstacle_manager so both sprites line up on the same lane centres.
package pickup_pkg;

  typedef enum logic {
    COIN = 1'b0,
    GEM  = 1'b1
  } pickup_kind_t;

  typedef enum logic {
    S_WAIT  = 1'b0,
    S_TRAIL = 1'b1
  } spawn_state_t;

  localparam logic [7:0] RESET_TIMER = 8'd30;
  localparam logic [7:0] WAIT_BASE   = 8'd55;

  function automatic logic [11:0] kind_points(input pickup_kind_t kind,
                                              input logic [11:0]  coinPts,
                                              input logic [11:0]  gemPts);
    return (kind == GEM) ? gemPts : coinPts;
  endfunction

  function automatic logic [11:0] lane_centre(input logic [1:0]  lane,
                                              input logic [11:0] lane0X,
                                              input logic [11:0] pitch);
    return lane0X + ({10'd0, lane} * pitch);
  endfunction

endpackage

// File: rtl/pickup_spawner.sv
// Spawn FSM: decides on each update edge whether a single pickup or the next
// coin of a same-lane trail is requested, and in which lane and kind.
module pickup_spawner
  import pickup_pkg::*;
#(
  parameter int NUM_LANES = 3,
  parameter int TRAIL_LEN = 5,
  parameter int TRAIL_GAP = 6
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         update,
  input  logic         clear,
  input  logic [15:0]  lfsr_val,
  output logic         spawn_req,
  output logic [1:0]   spawn_lane,
  output pickup_kind_t spawn_kind
);

  spawn_state_t r_state;
  logic [7:0]   r_timer;
  logic [7:0]   r_gap;
  logic [7:0]   r_remaining;
  logic [1:0]   r_trailLane;

  logic [1:0] w_randLane;
  logic       w_startTrail;
  logic [7:0] w_reload;
  logic       w_unusedLfsr;

  assign w_randLane   = ({1'b0, lfsr_val[5:4]} >= 3'(NUM_LANES)) ? 2'd0 : lfsr_val[5:4];
  assign w_startTrail = (TRAIL_LEN > 1) && lfsr_val[3];
  assign w_reload     = WAIT_BASE + {2'b00, lfsr_val[15:10]};
  assign w_unusedLfsr = ^lfsr_val[2:0];

  // The request is decoded from pre-edge state so the pool can place the
  // pickup on the same update edge that the FSM advances.
  always_comb begin
    spawn_req  = 1'b0;
    spawn_lane = w_randLane;
    spawn_kind = COIN;
    if (update && !clear) begin
      if (r_state == S_WAIT) begin
        if (r_timer == 8'd0) begin
          spawn_req = 1'b1;
          if (!w_startTrail && lfsr_val[9:7] == 3'd7) spawn_kind = GEM;
        end
      end else if (r_gap == 8'd0) begin
        spawn_req  = 1'b1;
        spawn_lane = r_trailLane;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_WAIT;
      r_timer     <= RESET_TIMER;
      r_gap       <= 8'd0;
      r_remaining <= 8'd0;
      r_trailLane <= 2'd0;
    end else if (clear) begin
      r_state     <= S_WAIT;
      r_timer     <= RESET_TIMER;
      r_gap       <= 8'd0;
      r_remaining <= 8'd0;
      r_trailLane <= 2'd0;
    end else if (update) begin
      case (r_state)
        S_WAIT: begin
          if (r_timer != 8'd0) begin
            r_timer <= r_timer - 8'd1;
          end else if (w_startTrail) begin
            r_trailLane <= w_randLane;
            r_remaining <= 8'(TRAIL_LEN - 1);
            r_gap       <= 8'(TRAIL_GAP);
            r_state     <= S_TRAIL;
          end else begin
            r_timer <= w_reload;
          end
        end
        S_TRAIL: begin
          if (r_gap != 8'd0) begin
            r_gap <= r_gap - 8'd1;
          end else begin
            // Trail counters advance even when the pool is full and the coin is dropped.
            r_gap       <= 8'(TRAIL_GAP);
            r_remaining <= r_remaining - 8'd1;
            if (r_remaining == 8'd1) begin
              r_timer <= w_reload;
              r_state <= S_WAIT;
            end
          end
        end
        default: r_state <= S_WAIT;
      endcase
    end
  end

endmodule

// File: rtl/pickup_manager.sv
// Parametrised coin/gem pickup pool with spawn FSM, registered collection events
// and per-pixel rendering. Define PICKUP_MAGNET_EN to add the magnet_on input.
module pickup_manager
  import pickup_pkg::*;
#(
  parameter int NUM_SLOTS     = 8,
  parameter int NUM_LANES     = 3,
  parameter int LANE0_X       = 144,
  parameter int LANE_PITCH    = 256,
  parameter int HALF          = 7,
  parameter int TRAIL_LEN     = 5,
  parameter int TRAIL_GAP     = 6,
  parameter int COIN_POINTS   = 50,
  parameter int GEM_POINTS    = 250,
  parameter int COLLECT_RANGE = 35,
  parameter int DEACTIVATE_Y  = 620
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        frame_done,
  input  logic        game_active,
  input  logic        clear,
  input  logic [15:0] lfsr_val,
  input  logic [3:0]  speed,
  input  logic [1:0]  player_lane,
  input  logic [9:0]  player_y,
  input  logic [9:0]  row,
  input  logic [9:0]  col,
`ifdef PICKUP_MAGNET_EN
  input  logic        magnet_on,
`endif
  output logic        pickup_pixel,
  output logic        pickup_is_gem,
  output logic        collect_pulse,
  output logic [11:0] collect_points,
  output logic [4:0]  collect_count
);

  logic [NUM_SLOTS-1:0] r_active;
  logic [1:0]           r_lane [NUM_SLOTS];
  logic [9:0]           r_y    [NUM_SLOTS];
  pickup_kind_t         r_kind [NUM_SLOTS];

  logic                 w_update;
  logic                 w_magnet;
  logic [9:0]           w_winLo;
  logic [10:0]          w_winHi;
  logic [NUM_SLOTS-1:0] w_hit;
  logic [NUM_SLOTS-1:0] w_freeOneHot;
  logic [NUM_SLOTS-1:0] w_draw;
  logic [11:0]          w_cx   [NUM_SLOTS];
  logic [4:0]           w_hitCount;
  logic [11:0]          w_hitPoints;
  logic                 w_spawnReq;
  logic [1:0]           w_spawnLane;
  pickup_kind_t         w_spawnKind;

  assign w_update = frame_done && game_active;

`ifdef PICKUP_MAGNET_EN
  assign w_magnet = magnet_on;
`else
  assign w_magnet = 1'b0;
`endif

  assign w_winLo      = (player_y >= 10'(COLLECT_RANGE)) ? player_y - 10'(COLLECT_RANGE) : 10'd0;
  assign w_winHi      = {1'b0, player_y} + 11'd10;
  assign w_freeOneHot = ~r_active & (r_active + {{(NUM_SLOTS-1){1'b0}}, 1'b1});

  pickup_spawner #(
    .NUM_LANES (NUM_LANES),
    .TRAIL_LEN (TRAIL_LEN),
    .TRAIL_GAP (TRAIL_GAP)
  ) u_spawner (
    .clock      (clock),
    .reset_n    (reset_n),
    .update     (w_update),
    .clear      (clear),
    .lfsr_val   (lfsr_val),
    .spawn_req  (w_spawnReq),
    .spawn_lane (w_spawnLane),
    .spawn_kind (w_spawnKind)
  );

  // Simultaneous hits are summed so two pickups in one frame are never lost.
  always_comb begin
    w_hitCount  = 5'd0;
    w_hitPoints = 12'd0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_hit[i] = r_active[i] && (w_magnet || r_lane[i] == player_lane) &&
                 (r_y[i] >= w_winLo) && ({1'b0, r_y[i]} <= w_winHi);
      if (w_hit[i]) begin
        w_hitCount  = w_hitCount + 5'd1;
        w_hitPoints = w_hitPoints + kind_points(r_kind[i], 12'(COIN_POINTS), 12'(GEM_POINTS));
      end
    end
  end

  always_comb begin
    pickup_is_gem = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_cx[i]   = lane_centre(r_lane[i], 12'(LANE0_X), 12'(LANE_PITCH));
      w_draw[i] = r_active[i] &&
                  ({2'b00, col} >= w_cx[i] - 12'(HALF)) && ({2'b00, col} < w_cx[i] + 12'(HALF)) &&
                  (row >= r_y[i]) && ({1'b0, row} < {1'b0, r_y[i]} + 11'(2 * HALF));
    end
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (w_draw[i]) pickup_is_gem = (r_kind[i] == GEM);
    end
  end

  assign pickup_pixel = |w_draw;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_active       <= '0;
      collect_pulse  <= 1'b0;
      collect_points <= 12'd0;
      collect_count  <= 5'd0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_lane[i] <= 2'd0;
        r_y[i]    <= 10'd0;
        r_kind[i] <= COIN;
      end
    end else if (clear) begin
      r_active       <= '0;
      collect_pulse  <= 1'b0;
      collect_points <= 12'd0;
      collect_count  <= 5'd0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_lane[i] <= 2'd0;
        r_y[i]    <= 10'd0;
        r_kind[i] <= COIN;
      end
    end else begin
      collect_pulse  <= 1'b0;
      collect_points <= 12'd0;
      collect_count  <= 5'd0;
      if (w_update) begin
        collect_pulse  <= |w_hit;
        collect_points <= w_hitPoints;
        collect_count  <= w_hitCount;
        // Only slots free before the edge accept a spawn; retiring slots wait a frame.
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (w_hit[i]) begin
            r_active[i] <= 1'b0;
          end else if (r_active[i]) begin
            if (r_y[i] >= 10'(DEACTIVATE_Y)) r_active[i] <= 1'b0;
            else r_y[i] <= r_y[i] + {6'd0, speed};
          end else if (w_spawnReq && w_freeOneHot[i]) begin
            r_active[i] <= 1'b1;
            r_lane[i]   <= w_spawnLane;
            r_y[i]      <= 10'd0;
            r_kind[i]   <= w_spawnKind;
          end
        end
      end
    end
  end

endmodule
